// File: rtl/spy_trigger_controller.sv
// Spy-buffer controller: records a tagged stream into a circular spy memory, keeps an
// event list of SOE addresses and wrap sentinels, and freezes on level request or trigger.
module spy_trigger_controller #(
  parameter int         DATAWIDTH = 64,
  parameter int         MEMWIDTH  = 6,
  parameter int         METAWIDTH = 4,
  parameter logic [7:0] SOE_CODE  = 8'hAB
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_freeze,
  input  logic                 i_arm,
  input  logic                 i_trigger,
  input  logic                 i_release,
  input  logic [MEMWIDTH-1:0]  i_post_count,
  input  logic [DATAWIDTH:0]   i_data_in,
  input  logic                 i_write_enable_in,
  input  logic [MEMWIDTH-1:0]  i_read_addr,
  input  logic                 i_read_enable_in,
  input  logic [METAWIDTH-1:0] i_meta_read_addr,
  input  logic                 i_meta_read_enable,
  output logic [DATAWIDTH:0]   o_data_out,
  output logic [MEMWIDTH-1:0]  o_mem_wptr,
  output logic [METAWIDTH-1:0] o_meta_write_addr,
  output logic [MEMWIDTH:0]    o_meta_read_data,
  output logic                 o_frozen,
  output logic                 o_freeze_cause,
  output logic [1:0]           o_state,
  output logic [MEMWIDTH-1:0]  o_trigger_addr,
  output logic [15:0]          o_wrap_count,
  output logic                 o_meta_overrun
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  localparam int                  MEM_DEPTH  = 1 << MEMWIDTH;
  localparam int                  META_DEPTH = 1 << METAWIDTH;
  localparam logic [MEMWIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [MEMWIDTH-1:0] REM_ONE    = 1;
  localparam logic [METAWIDTH-1:0] META_ONE  = 1;
  localparam logic [MEMWIDTH:0]   SENTINEL   = '1;

  state_t                r_state;
  logic                  r_cause;
  logic [MEMWIDTH-1:0]   r_wptr;
  logic [MEMWIDTH-1:0]   r_trig_addr;
  logic [MEMWIDTH-1:0]   r_remaining;
  logic [15:0]           r_wrap_count;
  logic [METAWIDTH-1:0]  r_meta_wa;
  logic                  r_pending;
  logic                  r_overrun;
  logic [DATAWIDTH:0]    r_data_out;
  logic [MEMWIDTH:0]     r_meta_rd;

  logic [DATAWIDTH:0]    r_mem  [MEM_DEPTH];
  logic [MEMWIDTH:0]     r_meta [META_DEPTH];

  logic                  w_accept;
  logic                  w_soe;
  logic                  w_wrap;
  logic                  w_push;
  logic                  w_drop;
  logic [MEMWIDTH:0]     w_push_data;

  assign w_accept = i_write_enable_in && (r_state != S_FROZEN);
  assign w_soe    = w_accept && i_data_in[DATAWIDTH] &&
                    (i_data_in[DATAWIDTH-1 -: 8] == SOE_CODE);
  assign w_wrap   = w_accept && (r_wptr == LAST_ADDR);

  // A held sentinel always owns the push slot; anything new in that cycle is lost.
  always_comb begin
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_push_data = '0;
    if (r_pending) begin
      w_push      = 1'b1;
      w_push_data = SENTINEL;
      w_drop      = w_soe || w_wrap;
    end else if (w_soe) begin
      w_push      = 1'b1;
      w_push_data = {1'b0, r_wptr};
    end else if (w_wrap) begin
      w_push      = 1'b1;
      w_push_data = SENTINEL;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_accept) r_mem[r_wptr] <= i_data_in;
    if (w_push)   r_meta[r_meta_wa] <= w_push_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr       <= '0;
      r_wrap_count <= '0;
      r_meta_wa    <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_data_out   <= '0;
      r_meta_rd    <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + REM_ONE;
      if (w_wrap && (r_wrap_count != 16'hFFFF)) r_wrap_count <= r_wrap_count + 16'd1;
      if (w_push) r_meta_wa <= r_meta_wa + META_ONE;
      r_pending <= !r_pending && w_soe && w_wrap;
      if (w_drop) r_overrun <= 1'b1;
      if (i_read_enable_in)   r_data_out <= r_mem[i_read_addr];
      if (i_meta_read_enable) r_meta_rd  <= r_meta[i_meta_read_addr];
    end
  end

  // Freeze always beats trigger, which beats arm; the trigger-cycle write is not counted.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_RUN;
      r_cause     <= 1'b0;
      r_trig_addr <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_freeze) begin
            r_state <= S_FROZEN;
            r_cause <= 1'b0;
          end else if (i_arm) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (i_freeze) begin
            r_state <= S_FROZEN;
            r_cause <= 1'b0;
          end else if (i_trigger) begin
            r_trig_addr <= r_wptr;
            r_remaining <= i_post_count;
            if (i_post_count == '0) begin
              r_state <= S_FROZEN;
              r_cause <= 1'b1;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (i_freeze) begin
            r_state <= S_FROZEN;
            r_cause <= 1'b0;
          end else if (w_accept) begin
            r_remaining <= r_remaining - REM_ONE;
            if (r_remaining == REM_ONE) begin
              r_state <= S_FROZEN;
              r_cause <= 1'b1;
            end
          end
        end
        S_FROZEN: begin
          if (!r_cause && !i_freeze) r_state <= S_RUN;
          else if (r_cause && i_release && !i_freeze) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_data_out        = r_data_out;
  assign o_mem_wptr        = r_wptr;
  assign o_meta_write_addr = r_meta_wa;
  assign o_meta_read_data  = r_meta_rd;
  assign o_frozen          = (r_state == S_FROZEN);
  assign o_freeze_cause    = r_cause;
  assign o_state           = r_state;
  assign o_trigger_addr    = r_trig_addr;
  assign o_wrap_count      = r_wrap_count;
  assign o_meta_overrun    = r_meta_overrun_q();

  function automatic logic r_meta_overrun_q();
    return r_overrun;
  endfunction

endmodule

// File: tb/tb_spy_trigger_controller.sv
// Directed bench for spy_trigger_controller: event-list, wrap, trigger/post, freeze and reset.
module tb_spy_trigger_controller;

  localparam int DW = 16;
  localparam int MW = 4;
  localparam int XW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze, arm, trigger, rel;
  logic [MW-1:0] post_count;
  logic [DW:0]   data_in;
  logic          we;
  logic [MW-1:0] read_addr;
  logic          re;
  logic [XW-1:0] meta_read_addr;
  logic          meta_re;
  logic [DW:0]   data_out;
  logic [MW-1:0] mem_wptr;
  logic [XW-1:0] meta_write_addr;
  logic [MW:0]   meta_read_data;
  logic          frozen, freeze_cause;
  logic [1:0]    state;
  logic [MW-1:0] trigger_addr;
  logic [15:0]   wrap_count;
  logic          meta_overrun;

  spy_trigger_controller #(.DATAWIDTH(DW), .MEMWIDTH(MW), .METAWIDTH(XW), .SOE_CODE(8'hAB)) dut (
    .i_clock(clk), .i_reset(rst), .i_freeze(freeze), .i_arm(arm), .i_trigger(trigger),
    .i_release(rel), .i_post_count(post_count), .i_data_in(data_in),
    .i_write_enable_in(we), .i_read_addr(read_addr), .i_read_enable_in(re),
    .i_meta_read_addr(meta_read_addr), .i_meta_read_enable(meta_re),
    .o_data_out(data_out), .o_mem_wptr(mem_wptr), .o_meta_write_addr(meta_write_addr),
    .o_meta_read_data(meta_read_data), .o_frozen(frozen), .o_freeze_cause(freeze_cause),
    .o_state(state), .o_trigger_addr(trigger_addr), .o_wrap_count(wrap_count),
    .o_meta_overrun(meta_overrun)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errs   = 0;
  logic [MW:0]   exp_q[$];
  logic [DW:0]   data_q[$];
  logic [DW:0]   m_mem [1 << MW];
  logic [MW-1:0] m_wptr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [DW:0] d, input bit acc);
    data_in = d;
    we      = 1'b1;
    tick();
    if (acc) begin
      m_mem[m_wptr] = d;
      m_wptr        = m_wptr + 1'b1;
    end
  endtask

  task automatic read_spy(input logic [MW-1:0] a, input string tag);
    we        = 1'b0;
    read_addr = a;
    re        = 1'b1;
    data_q.push_back(m_mem[a]);
    tick();
    re = 1'b0;
    check(tag, 32'(data_out), 32'(data_q.pop_front()));
  endtask

  task automatic read_meta(input logic [XW-1:0] a, input string tag);
    we             = 1'b0;
    meta_read_addr = a;
    meta_re        = 1'b1;
    tick();
    meta_re = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s observed=queue_empty expected=entry", tag);
    end else begin
      check(tag, 32'(meta_read_data), 32'(exp_q.pop_front()));
    end
  endtask

  function automatic logic [DW:0] rnd_word();
    return {1'b0, 16'($urandom_range(1, 65535))};
  endfunction

  function automatic logic [DW:0] soe_word(input logic [7:0] lo);
    return {1'b1, 8'hAB, lo};
  endfunction

  initial begin
    rst = 1'b1; freeze = 0; arm = 0; trigger = 0; rel = 0; post_count = '0;
    data_in = '0; we = 0; read_addr = '0; re = 0; meta_read_addr = '0; meta_re = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_state", 32'(state), 0);
    check("rst_wptr", 32'(mem_wptr), 0);
    check("rst_meta_wa", 32'(meta_write_addr), 0);
    check("rst_wrap", 32'(wrap_count), 0);
    check("rst_overrun", 32'(meta_overrun), 0);
    check("rst_frozen", 32'(frozen), 0);
    check("rst_data_out", 32'(data_out), 0);

    // 20 writes, SOE at writes 0 and 17, plus two near-miss words that must not push
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 17) do_write(soe_word(8'(i + 1)), 1'b1);
      else if (i == 5) do_write({1'b1, 8'h12, 8'h34}, 1'b1);
      else if (i == 6) do_write({1'b0, 8'hAB, 8'h56}, 1'b1);
      else do_write(rnd_word(), 1'b1);
      if (i == 0)  exp_q.push_back({1'b0, 4'h0});
      if (i == 15) exp_q.push_back(5'h1F);
      if (i == 17) exp_q.push_back({1'b0, 4'h1});
    end
    idle();
    check("t1_wptr", 32'(mem_wptr), 4);
    check("t1_wrap", 32'(wrap_count), 1);
    check("t1_meta_wa", 32'(meta_write_addr), 3);
    check("t1_overrun", 32'(meta_overrun), 0);
    read_meta(0, "t1_meta0");
    read_meta(1, "t1_meta1");
    read_meta(2, "t1_meta2");
    read_spy(0, "t1_spy0");
    read_spy(3, "t1_spy3");
    read_spy(4, "t1_spy4");
    read_spy(6, "t1_spy6");
    read_spy(15, "t1_spy15");

    // SOE landing on the last address: SOE entry then sentinel the next cycle
    for (int i = 4; i < 15; i++) do_write(rnd_word(), 1'b1);
    do_write(soe_word(8'h77), 1'b1);
    exp_q.push_back({1'b0, 4'hF});
    exp_q.push_back(5'h1F);
    idle();
    check("t2_meta_wa", 32'(meta_write_addr), 5);
    check("t2_overrun", 32'(meta_overrun), 0);
    check("t2_wrap", 32'(wrap_count), 2);
    read_meta(3, "t2_meta3");
    read_meta(4, "t2_meta4");

    // Same again, followed at once by an SOE at address 0, which is dropped
    for (int i = 0; i < 15; i++) do_write(rnd_word(), 1'b1);
    do_write(soe_word(8'h88), 1'b1);
    do_write(soe_word(8'h99), 1'b1);
    exp_q.push_back({1'b0, 4'hF});
    exp_q.push_back(5'h1F);
    idle();
    check("t2b_meta_wa", 32'(meta_write_addr), 7);
    check("t2b_overrun", 32'(meta_overrun), 1);
    check("t2b_wptr", 32'(mem_wptr), 1);
    read_meta(5, "t2b_meta5");
    read_meta(6, "t2b_meta6");
    read_spy(0, "t2b_spy0");

    // Arm, trigger at wptr 5 with post_count 3
    for (int i = 1; i < 5; i++) do_write(rnd_word(), 1'b1);
    arm = 1'b1; idle(); arm = 1'b0;
    check("t3_armed", 32'(state), 1);
    trigger = 1'b1; post_count = 4'd3;
    do_write(rnd_word(), 1'b1);
    trigger = 1'b0; post_count = '0;
    check("t3_post", 32'(state), 2);
    check("t3_trig_addr", 32'(trigger_addr), 5);
    do_write(rnd_word(), 1'b1);
    do_write(rnd_word(), 1'b1);
    check("t3_still_post", 32'(state), 2);
    do_write(rnd_word(), 1'b1);
    check("t3_frozen_state", 32'(state), 3);
    check("t3_frozen", 32'(frozen), 1);
    check("t3_cause", 32'(freeze_cause), 1);
    check("t3_wptr", 32'(mem_wptr), 9);
    do_write(rnd_word(), 1'b0);
    do_write(rnd_word(), 1'b0);
    check("t3_blocked_wptr", 32'(mem_wptr), 9);
    read_spy(9, "t3_spy9_untouched");
    read_spy(5, "t3_spy5");
    check("t3_hold", 32'(state), 3);
    rel = 1'b1; idle(); rel = 1'b0;
    check("t3_release", 32'(state), 0);

    // post_count = 0 freezes right after the trigger cycle
    arm = 1'b1; idle(); arm = 1'b0;
    trigger = 1'b1; post_count = '0;
    do_write(rnd_word(), 1'b1);
    trigger = 1'b0;
    check("t4_state", 32'(state), 3);
    check("t4_cause", 32'(freeze_cause), 1);
    check("t4_trig_addr", 32'(trigger_addr), 9);
    check("t4_wptr", 32'(mem_wptr), 10);
    idle();
    check("t4_no_release", 32'(state), 3);
    rel = 1'b1; idle(); rel = 1'b0;
    check("t4_release", 32'(state), 0);

    // Level freeze for 4 cycles in POST
    arm = 1'b1; idle(); arm = 1'b0;
    trigger = 1'b1; post_count = 4'd5;
    do_write(rnd_word(), 1'b1);
    trigger = 1'b0;
    check("t5_post", 32'(state), 2);
    freeze = 1'b1;
    do_write(rnd_word(), 1'b1);
    check("t5_frozen", 32'(state), 3);
    check("t5_cause", 32'(freeze_cause), 0);
    check("t5_wptr_first", 32'(mem_wptr), 12);
    for (int i = 0; i < 3; i++) do_write(rnd_word(), 1'b0);
    check("t5_wptr_held", 32'(mem_wptr), 12);
    check("t5_still_frozen", 32'(frozen), 1);
    freeze = 1'b0;
    idle();
    check("t5_run", 32'(state), 0);

    // Asynchronous reset mid-POST
    arm = 1'b1; idle(); arm = 1'b0;
    trigger = 1'b1; post_count = 4'd7;
    do_write(rnd_word(), 1'b1);
    trigger = 1'b0;
    do_write(rnd_word(), 1'b1);
    we = 1'b0;
    check("t6_post", 32'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_state", 32'(state), 0);
    check("t6_wptr", 32'(mem_wptr), 0);
    check("t6_trig_addr", 32'(trigger_addr), 0);
    check("t6_wrap", 32'(wrap_count), 0);
    check("t6_overrun", 32'(meta_overrun), 0);
    check("t6_meta_wa", 32'(meta_write_addr), 0);
    check("t6_data_out", 32'(data_out), 0);
    check("t6_meta_rd", 32'(meta_read_data), 0);
    check("t6_frozen", 32'(frozen), 0);
    check("t6_cause", 32'(freeze_cause), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/spy_trigger_controller.md
# spy_trigger_controller

Next-generation spy-buffer controller: records a tagged data stream into a circular spy memory and maintains an event list of start-of-event (SOE) addresses plus wrap sentinels. Adds what the plain freeze-only controller lacks: an arm/trigger/post-trigger freeze mode with a programmable post-trigger depth, a captured trigger address, a wrap counter and an event-list overrun flag. Sits between the data path tap and the spy readout logic; both memories are internal.

## Interface

- DATAWIDTH, 64, payload width; data word is DATAWIDTH+1 bits (MSB = metadata flag)
- MEMWIDTH, 6, spy memory address bits (depth 2^MEMWIDTH)
- METAWIDTH, 4, event list address bits (depth 2^METAWIDTH)
- SOE_CODE, 8'hAB, value of data_in[DATAWIDTH-1 -: 8] marking SOE when data_in[DATAWIDTH]=1

- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- freeze  in  1  level freeze request
- arm  in  1  pulse, arms trigger mode
- trigger  in  1  pulse, trigger event
- release  in  1  pulse, leaves a trigger-caused freeze
- post_count  in  MEMWIDTH  accepted writes to record after trigger; sampled in the trigger cycle
- data_in  in  DATAWIDTH+1  data to record
- write_enable_in  in  1  data_in valid
- read_addr  in  MEMWIDTH  spy memory read address
- read_enable_in  in  1  spy memory read strobe
- meta_read_addr  in  METAWIDTH  event list read address
- meta_read_enable  in  1  event list read strobe
- data_out  out  DATAWIDTH+1  spy read data
- mem_wptr  out  MEMWIDTH  next spy write address
- meta_write_addr  out  METAWIDTH  next event list write address
- meta_read_data  out  MEMWIDTH+1  event list read data
- frozen  out  1  state == FROZEN
- freeze_cause  out  1  0 = level freeze, 1 = trigger
- state  out  2  RUN=0, ARMED=1, POST=2, FROZEN=3
- trigger_addr  out  MEMWIDTH  mem_wptr captured at trigger
- wrap_count  out  16  spy memory wraps, saturating at 16'hFFFF
- meta_overrun  out  1  sticky, an event-list entry was dropped

## Operation

- Accepted write: write_enable_in && state != FROZEN (registered state). Writes data_in at mem_wptr; mem_wptr increments mod 2^MEMWIDTH.
- SOE: accepted write with data_in[DATAWIDTH]=1 and data_in[DATAWIDTH-1 -: 8]==SOE_CODE; pushes {1'b0, written address}.
- Wrap: accepted write at address 2^MEMWIDTH-1; pushes sentinel {1'b1, all-ones}; wrap_count increments.
- One event-list push per cycle. On SOE+wrap in the same write, SOE is pushed that cycle and the sentinel is held pending and pushed next cycle. If a new entry also arises that cycle, the pending sentinel wins, the new entry is dropped and meta_overrun sets. Input contract: no two consecutive SOE words.
- Event-list pushes are not gated by FROZEN. meta_write_addr increments mod 2^METAWIDTH and overwrites old entries.
- State machine (next state registered):
  - RUN: freeze -> FROZEN (cause 0); arm -> ARMED.
  - ARMED: freeze -> FROZEN (cause 0); trigger -> capture trigger_addr=mem_wptr and load remaining=post_count, then to FROZEN (cause 1) if post_count==0, else to POST.
  - POST: freeze -> FROZEN (cause 0); each accepted write decrements remaining; the accepted write with remaining==1 -> FROZEN (cause 1).
  - FROZEN: cause 0 -> RUN when freeze low. Cause 1 -> RUN when release && !freeze.
- Priority: freeze > trigger > arm. arm/trigger in other states are ignored. A trigger-cycle write is accepted and is not counted.
- Reads allowed in every state.

## Timing

- Reset: all outputs, pointers, counters, flags and the pending sentinel = 0; state = RUN. Memory contents undefined. A reset mid-POST or mid-FROZEN returns to RUN immediately.
- Freeze latency: a write in the cycle freeze first asserts is accepted; writes are blocked from the next cycle. frozen rises one cycle after freeze.
- data_out and meta_read_data: registered, 1-cycle latency after the read strobe; held otherwise.
- Read-during-write to the same address returns old data.
- mem_wptr, meta_write_addr and wrap_count update one cycle after the accepted write/push.

## Test plan

- MEMWIDTH=4: 20 accepted writes, SOE at writes 0 and 17 -> event list {0,0x0}, {1,0xF}, {0,0x1}; mem_wptr=4; wrap_count=1.
- SOE at address 0xF -> {0,0xF} pushed, then {1,0xF} the next cycle; meta_overrun=0. Same plus SOE at address 0x0 -> meta_overrun=1, and the 0x0 entry is absent.
- arm, trigger at mem_wptr=5, post_count=3, continuous writes -> trigger_addr=5; frozen after the 3rd post-trigger write; mem_wptr=9; further writes ignored; release -> RUN.
- post_count=0 -> FROZEN the cycle after trigger, mem_wptr=trigger_addr+1; freeze_cause=1.
- freeze high 4 cycles during POST -> FROZEN cause 0; RUN one cycle after freeze drops.
- Reset asserted mid-POST -> all outputs 0 asynchronously; state=RUN.
